// File: rtl/flip_select_sequencer_pkg.sv
// Shared SAT constants, sequencer state encoding and the literal-to-wren code
// used by the flip-select sequencer and the variable flip selector.
package flip_select_sequencer_pkg;

    localparam int SAT_NSAT        = 3;
    localparam int SAT_VAR_BITS    = 16;
    localparam int SAT_MAX_CLAUSES = 20;
    localparam int WREN_BITS       = $clog2(SAT_NSAT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_CAPTURE
    } seq_state_t;

    // The last literal writes all slots at once so the selector sees a complete clause.
    function automatic logic [WREN_BITS-1:0] wren_code(input logic [WREN_BITS-1:0] idx);
        if (idx >= WREN_BITS'(SAT_NSAT - 1)) begin
            return '1;
        end
        return WREN_BITS'(1) << idx;
    endfunction

endpackage

// File: rtl/flip_select_sequencer.sv
// Walks the literals of one clause, fetches each variable's break/mask vectors
// and feeds them to the flip selector. Optional timeout: FLIP_SEQ_TIMEOUT_EN.
module flip_select_sequencer
    import flip_select_sequencer_pkg::*;
#(
    parameter int MAX_CLAUSES_PER_VARIABLE = SAT_MAX_CLAUSES,
    parameter int NSAT                     = SAT_NSAT,
    parameter int VAR_BITS                 = SAT_VAR_BITS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start_i,
    input  logic [NSAT*VAR_BITS-1:0]            clause_vars_i,
    output logic                                mem_req_o,
    output logic [VAR_BITS-1:0]                 mem_addr_o,
    input  logic                                mem_gnt_i,
    input  logic                                mem_rvalid_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] mem_broken_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] mem_mask_i,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_bits_o,
    output logic [$clog2(NSAT)-1:0]             wren_o,
    output logic [NSAT-1:0]                     break_values_valid_o,
    input  logic [$clog2(NSAT)-1:0]             selected_i,
    output logic                                busy_o,
`ifdef FLIP_SEQ_TIMEOUT_EN
    output logic                                timeout_o,
`endif
    output logic                                done_o,
    output logic                                flip_valid_o,
    output logic [VAR_BITS-1:0]                 flip_var_o
);

    localparam int LIT_BITS = $clog2(NSAT);

    seq_state_t                      state_q, state_d;
    logic [NSAT-1:0][VAR_BITS-1:0]   vars_q;
    logic [LIT_BITS-1:0]             lit_q;
    logic [VAR_BITS-1:0]             cur_var;
    logic                            last_lit;
    logic                            load_zero;
    logic                            load_resp;
    logic                            tmo_fire;
    logic                            accept_start;

    assign cur_var      = vars_q[lit_q];
    assign last_lit     = (lit_q == LIT_BITS'(NSAT - 1));
    assign accept_start = (state_q == ST_IDLE) && start_i;
    assign busy_o       = (state_q != ST_IDLE);

`ifdef FLIP_SEQ_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       tmo_hit;

    assign tmo_hit = (tmo_cnt_q == 8'hFF);

    // Restarts on every state change so REQ and WAIT each get a full budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_o <= 1'b0;
        end else begin
            if ((state_d != state_q) || !(state_q inside {ST_REQ, ST_WAIT})) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
            if (accept_start) begin
                timeout_o <= 1'b0;
            end else if (tmo_fire) begin
                timeout_o <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d      = state_q;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        wren_o       = '0;
        load_zero    = 1'b0;
        load_resp    = 1'b0;
        tmo_fire     = 1'b0;
        done_o       = 1'b0;
        flip_valid_o = 1'b0;
        flip_var_o   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (cur_var == '0) begin
                    load_zero = 1'b1;
                    state_d   = ST_WRITE;
                end else begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = cur_var;
                    if (mem_gnt_i) begin
                        state_d = ST_WAIT;
                    end
`ifdef FLIP_SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        tmo_fire  = 1'b1;
                        load_zero = 1'b1;
                        state_d   = ST_WRITE;
                    end
`endif
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    load_resp = 1'b1;
                    state_d   = ST_WRITE;
                end
`ifdef FLIP_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    load_zero = 1'b1;
                    state_d   = ST_WRITE;
                end
`endif
            end
            ST_WRITE: begin
                wren_o  = wren_code(lit_q);
                state_d = last_lit ? ST_CAPTURE : ST_REQ;
            end
            ST_CAPTURE: begin
                done_o       = 1'b1;
                flip_valid_o = |break_values_valid_o;
                if (selected_i < LIT_BITS'(NSAT)) begin
                    flip_var_o = vars_q[selected_i];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vars_q               <= '0;
            lit_q                <= '0;
            break_values_valid_o <= '0;
            clause_broken_o      <= '0;
            mask_bits_o          <= '0;
        end else begin
            if (accept_start) begin
                vars_q <= clause_vars_i;
                lit_q  <= '0;
                for (int k = 0; k < NSAT; k++) begin
                    break_values_valid_o[k] <= (clause_vars_i[k*VAR_BITS +: VAR_BITS] != '0);
                end
            end
            if (load_zero) begin
                clause_broken_o <= '0;
                mask_bits_o     <= '0;
            end
            if (load_resp) begin
                clause_broken_o <= mem_broken_i;
                mask_bits_o     <= mem_mask_i;
            end
            if (tmo_fire) begin
                break_values_valid_o[lit_q] <= 1'b0;
            end
            if ((state_q == ST_WRITE) && !last_lit) begin
                lit_q <= lit_q + LIT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_flip_select_sequencer.sv
// Directed bench for flip_select_sequencer: the bench acts as the memory,
// and a scoreboard of expected writes and results is checked as the DUT emits them.
module tb_flip_select_sequencer;
    import flip_select_sequencer_pkg::*;

    localparam int MC = 20;
    localparam int NS = 3;
    localparam int VB = 16;
    localparam int LB = 2;

    typedef struct {
        logic [LB-1:0] wren;
        logic [MC-1:0] broken;
        logic [MC-1:0] mask;
    } wr_exp_t;

    typedef struct {
        logic [VB-1:0] flip_var;
        logic          flip_valid;
        int            done_cycle;
        int            reqs;
    } res_exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic [NS*VB-1:0]  clause_vars_i;
    logic              mem_req_o;
    logic [VB-1:0]     mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [MC-1:0]     mem_broken_i;
    logic [MC-1:0]     mem_mask_i;
    logic [MC-1:0]     clause_broken_o;
    logic [MC-1:0]     mask_bits_o;
    logic [LB-1:0]     wren_o;
    logic [NS-1:0]     break_values_valid_o;
    logic [LB-1:0]     selected_i;
    logic              busy_o;
    logic              done_o;
    logic              flip_valid_o;
    logic [VB-1:0]     flip_var_o;
`ifdef FLIP_SEQ_TIMEOUT_EN
    logic              timeout_o;
`endif

    int tests = 0;
    int fails = 0;
    int cycle;
    wr_exp_t  wr_q[$];
    res_exp_t res_q[$];

    always #5 clk = ~clk;

    flip_select_sequencer #(
        .MAX_CLAUSES_PER_VARIABLE(MC),
        .NSAT(NS),
        .VAR_BITS(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_i(start_i),
        .clause_vars_i(clause_vars_i),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_broken_i(mem_broken_i),
        .mem_mask_i(mem_mask_i),
        .clause_broken_o(clause_broken_o),
        .mask_bits_o(mask_bits_o),
        .wren_o(wren_o),
        .break_values_valid_o(break_values_valid_o),
        .selected_i(selected_i),
        .busy_o(busy_o),
`ifdef FLIP_SEQ_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .done_o(done_o),
        .flip_valid_o(flip_valid_o),
        .flip_var_o(flip_var_o)
    );

    function automatic logic [MC-1:0] broken_of(input logic [VB-1:0] a);
        return (MC'(a) * MC'(3)) ^ MC'(20'h0A5A5);
    endfunction

    function automatic logic [MC-1:0] mask_of(input logic [VB-1:0] a);
        return {a, 4'hF};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one clause and plays memory; no_rv_lit names a literal that never gets rvalid.
    task automatic run_seq(input logic [VB-1:0] v0, input logic [VB-1:0] v1,
                           input logic [VB-1:0] v2, input int gnt_dly, input int rv_dly,
                           input int sel, input bit poke_start, input int no_rv_lit);
        logic [VB-1:0] v [NS];
        logic [NS-1:0] exp_bvv;
        logic [NS-1:0] fin_bvv;
        logic [VB-1:0] held_addr;
        logic [VB-1:0] pend_addr;
        int            exp_cycle, exp_reqs, n_reqs, req_wait, rv_cnt, wr_seen;
        bit            in_wait, holding, got_done;
        res_exp_t      r;
        v[0] = v0; v[1] = v1; v[2] = v2;
        exp_cycle = 1; exp_reqs = 0; exp_bvv = '0; fin_bvv = '0;
        for (int k = 0; k < NS; k++) begin
            wr_exp_t w;
            w.wren = (k == NS - 1) ? 2'b11 : LB'(1 << k);
            w.broken = '0;
            w.mask   = '0;
            if (v[k] == '0) begin
                exp_cycle += 2;
            end else if (k == no_rv_lit) begin
                exp_cycle += (1 + gnt_dly) + 256 + 1;
                exp_reqs++;
                exp_bvv[k] = 1'b1;
            end else begin
                exp_cycle += (1 + gnt_dly) + (1 + rv_dly) + 1;
                exp_reqs++;
                exp_bvv[k] = 1'b1;
                fin_bvv[k] = 1'b1;
                w.broken = broken_of(v[k]);
                w.mask   = mask_of(v[k]);
            end
            wr_q.push_back(w);
        end
        r.flip_var   = (sel < NS) ? v[sel] : '0;
        r.flip_valid = |fin_bvv;
        r.done_cycle = exp_cycle;
        r.reqs       = exp_reqs;
        res_q.push_back(r);

        clause_vars_i = {v2, v1, v0};
        selected_i    = LB'(sel);
        start_i       = 1'b1;
        cycle = 0; n_reqs = 0; req_wait = 0; rv_cnt = 0; wr_seen = 0;
        in_wait = 0; holding = 0; got_done = 0;
        held_addr = '0; pend_addr = '0;
        while (!got_done && cycle < 2000) begin
            @(negedge clk);
            cycle++;
            start_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            mem_broken_i = '0; mem_mask_i = '0;
            if (cycle == 1) begin
                check("bvv_init", break_values_valid_o, exp_bvv);
                check("busy_run", busy_o, 1'b1);
            end
            if (poke_start && cycle == 5) begin
                start_i = 1'b1;
                clause_vars_i = ~clause_vars_i;
            end
            if (wren_o != '0) begin
                in_wait = 0;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", wren_o, '0);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    check("wren", wren_o, w.wren);
                    check("broken", clause_broken_o, w.broken);
                    check("mask", mask_bits_o, w.mask);
                end
                wr_seen++;
            end else if (in_wait) begin
                if (wr_seen != no_rv_lit && rv_cnt >= rv_dly) begin
                    mem_rvalid_i = 1'b1;
                    mem_broken_i = broken_of(pend_addr);
                    mem_mask_i   = mask_of(pend_addr);
                    in_wait = 0;
                end else begin
                    rv_cnt++;
                end
            end else if (mem_req_o) begin
                if (!holding) begin
                    held_addr = mem_addr_o;
                    holding = 1;
                    check("req_addr", mem_addr_o, (wr_seen < NS) ? v[wr_seen] : '0);
                end else begin
                    check("addr_hold", mem_addr_o, held_addr);
                end
                if (req_wait >= gnt_dly) begin
                    mem_gnt_i = 1'b1;
                    n_reqs++;
                    pend_addr = mem_addr_o;
                    in_wait = 1; rv_cnt = 0; req_wait = 0; holding = 0;
                end else begin
                    req_wait++;
                end
            end
            if (done_o) begin
                got_done = 1;
                r = res_q.pop_front();
                check("done_cycle", cycle, r.done_cycle);
                check("flip_var", flip_var_o, r.flip_var);
                check("flip_valid", flip_valid_o, r.flip_valid);
                check("req_count", n_reqs, r.reqs);
                check("writes", wr_seen, NS);
                check("wren_capture", wren_o, '0);
`ifdef FLIP_SEQ_TIMEOUT_EN
                check("timeout_flag", timeout_o, (no_rv_lit >= 0) ? 1'b1 : 1'b0);
                if (no_rv_lit >= 0) check("bvv_timeout", break_values_valid_o, fin_bvv);
`endif
            end
        end
        if (!got_done) check("done_seen", 1'b0, 1'b1);
        @(negedge clk);
        start_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        check("done_pulse", done_o, 1'b0);
        check("idle_after", busy_o, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_req"}, mem_req_o, 1'b0);
        check({tag, "_addr"}, mem_addr_o, '0);
        check({tag, "_wren"}, wren_o, '0);
        check({tag, "_done"}, done_o, 1'b0);
        check({tag, "_fvalid"}, flip_valid_o, 1'b0);
        check({tag, "_fvar"}, flip_var_o, '0);
        check({tag, "_bvv"}, break_values_valid_o, '0);
        check({tag, "_broken"}, clause_broken_o, '0);
        check({tag, "_mask"}, mask_bits_o, '0);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; clause_vars_i = '0; selected_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_broken_i = '0; mem_mask_i = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_seq(16'd5, 16'd9, 16'd12, 0, 0, 1, 1'b0, -1);
        run_seq(16'd7, 16'd0, 16'd3, 0, 0, 2, 1'b0, -1);
        run_seq(16'd0, 16'd0, 16'd0, 0, 0, 0, 1'b0, -1);
        run_seq(16'd21, 16'd22, 16'd23, 3, 4, 0, 1'b1, -1);

        // Reset while waiting on literal 1's response, then a stale rvalid.
        clause_vars_i = {16'd8, 16'd6, 16'd4};
        selected_i = '0;
        start_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            mem_gnt_i = mem_req_o;
            mem_rvalid_i = (c == 2);
            mem_broken_i = broken_of(16'd4);
            mem_mask_i = mask_of(16'd4);
        end
        @(negedge clk);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        check("wait1_busy", busy_o, 1'b1);
        check("wait1_data", clause_broken_o, broken_of(16'd4));
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_broken_i = broken_of(16'd6);
        mem_mask_i = mask_of(16'd6);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        check("late_rv_busy", busy_o, 1'b0);
        check("late_rv_broken", clause_broken_o, '0);
        check("late_rv_wren", wren_o, '0);

        run_seq(16'd4, 16'd6, 16'd8, 0, 0, 2, 1'b0, -1);
`ifdef FLIP_SEQ_TIMEOUT_EN
        run_seq(16'd10, 16'd11, 16'd12, 0, 0, 0, 1'b0, 2);
        run_seq(16'd1, 16'd2, 16'd3, 0, 1, 1, 1'b0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flip_select_sequencer.md
FLIP_SELECT_SEQUENCER -- requirements
Module: flip_select_sequencer

Interface
REQ-001 SHALL have parameters: MAX_CLAUSES_PER_VARIABLE, default 20, width of per-variable clause vectors; NSAT, default 3, literals per clause (only 3 legal); VAR_BITS, default 16, variable index width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports: clk input 1 rising-edge clock; reset input 1 asynchronous active-high reset.
REQ-003 start_i input 1: begin sequence for the presented clause.
REQ-004 clause_vars_i input NSAT*VAR_BITS: variable index per literal, slice k = literal k; index 0 = empty literal.
REQ-005 mem_req_o output 1, mem_addr_o output VAR_BITS, mem_gnt_i input 1: request handshake, address held until grant.
REQ-006 mem_rvalid_i input 1, mem_broken_i input MAX_CLAUSES_PER_VARIABLE, mem_mask_i input MAX_CLAUSES_PER_VARIABLE: read response.
REQ-007 clause_broken_o, mask_bits_o output MAX_CLAUSES_PER_VARIABLE each; wren_o output clog2(NSAT); break_values_valid_o output NSAT: drive the flip selector.
REQ-008 selected_i input clog2(NSAT): registered selection from the flip selector.
REQ-009 busy_o output 1; done_o output 1 (one-cycle pulse); flip_valid_o output 1; flip_var_o output VAR_BITS.

Function
REQ-010 States: IDLE, REQ, WAIT, WRITE, CAPTURE.
REQ-011 IDLE: on start_i, register clause_vars_i, set break_values_valid_o[k] = (var k != 0), literal counter = 0, go REQ; start_i ignored in every other state.
REQ-012 REQ: mem_req_o=1, mem_addr_o = var[counter]; on mem_gnt_i go WAIT; if var[counter]==0, no request, load zero data, go WRITE.
REQ-013 WAIT: on mem_rvalid_i capture mem_broken_i/mem_mask_i into output registers, go WRITE.
REQ-014 WRITE: one cycle, wren_o = one-hot bit counter for counter<NSAT-1, all-ones for counter==NSAT-1; clause_broken_o/mask_bits_o stable throughout; then counter+1 and REQ, or CAPTURE after last literal.
REQ-015 wren_o SHALL be all-zeros in every state except WRITE.
REQ-016 CAPTURE: flip_var_o = var[selected_i], flip_valid_o = |break_values_valid_o, done_o=1 for one cycle, go IDLE.
REQ-017 Latency with grant in request cycle and rvalid next cycle: done_o asserted 10 cycles after the start_i cycle; each wait cycle adds one.
REQ-018 busy_o = (state != IDLE).
REQ-019 mem_rvalid_i outside WAIT and mem_gnt_i outside REQ SHALL be ignored.

Reset
REQ-020 Reset SHALL force IDLE immediately, even mid-sequence, and clear all outputs: wren_o=0, mem_req_o=0, done_o=0, flip_valid_o=0, flip_var_o=0, data/valid registers 0.
REQ-021 A response arriving after reset deassertion for a pre-reset request SHALL be ignored (state IDLE).

Configuration
REQ-022 Macro FLIP_SEQ_TIMEOUT_EN: when defined, an 8-bit counter runs in REQ and WAIT; at 255 cycles without grant/rvalid, load zero data, clear break_values_valid_o[counter], go WRITE, and set sticky timeout_o (output 1, cleared on next start_i); when undefined, no counter, no timeout_o port, waits indefinitely.

Structure
REQ-023 State encoding enum and the wren code function (literal index -> wren value) SHALL live in the shared SAT package with the NSAT/width constants.
REQ-024 Single module, no sub-modules; intended to instantiate alongside the variable flip selector.

Verification
REQ-025 Vars (5,9,12), zero-wait memory, selected_i=1 in CAPTURE -> wren_o sequence 01,10,11; done_o at cycle 10; flip_var_o=9, flip_valid_o=1.
REQ-026 Vars (7,0,3) -> only two mem_req_o; break_values_valid_o=101; literal 1 written with zero data.
REQ-027 Vars (0,0,0) -> no requests; done_o with flip_valid_o=0.
REQ-028 Grant delayed 3 cycles, rvalid delayed 4 -> mem_addr_o stable until grant; done_o at cycle 31; second start_i during busy ignored.
REQ-029 Reset asserted in WAIT of literal 1 -> IDLE and all outputs zero same cycle; late mem_rvalid_i ignored; new start_i completes normally.
REQ-030 With FLIP_SEQ_TIMEOUT_EN, no rvalid for literal 2 -> after 255 cycles timeout_o=1, break_values_valid_o[2]=0, done_o follows.
